// File: rtl/cmd_response_receiver.sv
// SD CMD-line response receiver: hunts for the start bit, deserializes a 48/136-bit frame
// MSB-first, then checks the transmission bit, CRC7 and end bit.
module cmd_response_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned SHORT_LEN      = 48,
    parameter int unsigned LONG_LEN       = 136
) (
    input  logic         clk_SD,
    input  logic         reset_host,
    input  logic         enable_rx,
    input  logic         long_response,
    input  logic         crc_check_en,
    input  logic         CMD_PIN_IN,
    output logic [135:0] response,
    output logic         rx_complete,
    output logic         busy,
    output logic         timeout_error,
    output logic         crc_error,
    output logic         frame_error
);

    localparam logic [7:0] SHORT_N       = 8'(SHORT_LEN);
    localparam logic [7:0] LONG_N        = 8'(LONG_LEN);
    localparam logic [7:0] SHORT_CRC_END = 8'(SHORT_LEN - 8);
    localparam logic [7:0] LONG_CRC_BEG  = 8'(LONG_LEN - 128);
    localparam logic [7:0] LONG_CRC_END  = 8'(LONG_LEN - 8);
    localparam logic [6:0] TO_LAST       = 7'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWaitStart, StReceive, StCheck} state_t;

    state_t         r_state;
    logic [135:0]   r_shift;
    logic [7:0]     r_bit_cnt;
    logic [6:0]     r_to_cnt;
    logic [6:0]     r_crc;
    logic           r_long;
    logic           r_crc_en;

    logic [7:0]     w_frame_len;
    logic           w_crc_in;
    logic           w_crc_fb;
    logic [6:0]     w_crc_next;
    logic           w_tx_bit;
    logic           w_frame_err;
    logic           w_crc_err;

    // r_bit_cnt holds bits already received, so the incoming bit is number r_bit_cnt+1.
    // Long frames exclude the 8 header bits; the start bit of either frame is zero and
    // leaves the zero-initialised CRC register unchanged, so it needs no update.
    always_comb begin
        w_frame_len = r_long ? LONG_N : SHORT_N;
        w_crc_in    = r_long ? ((r_bit_cnt >= LONG_CRC_BEG) && (r_bit_cnt < LONG_CRC_END))
                             : (r_bit_cnt < SHORT_CRC_END);
        w_crc_fb    = r_crc[6] ^ CMD_PIN_IN;
        w_crc_next  = {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);
        w_tx_bit    = r_long ? r_shift[LONG_LEN-2] : r_shift[SHORT_LEN-2];
        w_frame_err = w_tx_bit | ~r_shift[0];
        w_crc_err   = r_crc_en & (r_crc != r_shift[7:1]);
    end

    always_ff @(posedge clk_SD) begin
        if (reset_host) begin
            r_state       <= StIdle;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_to_cnt      <= '0;
            r_crc         <= '0;
            r_long        <= 1'b0;
            r_crc_en      <= 1'b0;
            response      <= '0;
            rx_complete   <= 1'b0;
            busy          <= 1'b0;
            timeout_error <= 1'b0;
            crc_error     <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            rx_complete <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (enable_rx) begin
                        r_long        <= long_response;
                        r_crc_en      <= crc_check_en;
                        response      <= '0;
                        timeout_error <= 1'b0;
                        crc_error     <= 1'b0;
                        frame_error   <= 1'b0;
                        r_shift       <= '0;
                        r_bit_cnt     <= '0;
                        r_to_cnt      <= '0;
                        r_crc         <= '0;
                        busy          <= 1'b1;
                        r_state       <= StWaitStart;
                    end
                end
                StWaitStart: begin
                    if (!CMD_PIN_IN) begin
                        r_shift   <= {r_shift[134:0], 1'b0};
                        r_bit_cnt <= 8'd1;
                        r_crc     <= '0;
                        r_state   <= StReceive;
                    end else if (r_to_cnt == TO_LAST) begin
                        timeout_error <= 1'b1;
                        rx_complete   <= 1'b1;
                        busy          <= 1'b0;
                        r_state       <= StIdle;
                    end else begin
                        r_to_cnt <= r_to_cnt + 7'd1;
                    end
                end
                StReceive: begin
                    r_shift   <= {r_shift[134:0], CMD_PIN_IN};
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                    if (w_crc_in) begin
                        r_crc <= w_crc_next;
                    end
                    if (r_bit_cnt == w_frame_len - 8'd1) begin
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    response    <= r_shift;
                    frame_error <= w_frame_err;
                    crc_error   <= w_crc_err;
                    rx_complete <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
